// File: rtl/fmac_vc_credit_bank.sv
// VC credit bank: per-channel credit counters with saturating net updates,
// VC_ID slot table and interval min/max/end/time-at-min statistics.
//
// Ports:
//   clk, rst_n               clock, async active-low reset
//   reg_fmac_credit_start    counter reload value
//   reg_link_up_cnt_en       link-up pulse, reloads all counters
//   vc_tbl_clr               invalidate all slots, clear overflow
//   vc_id / vc_id_ld         per-slot VC_ID and load request
//   pair_vc_rdy_event        per-slot VC_RDY event (+1 credit)
//   reg_sof_cnt_en/sof_vc_id SOF event (-1 credit)
//   int_stats_latch_clr      latch and clear interval stats
//   stats_rd_idx             readout channel select
//   int_stats_*              latched stats of selected channel (registered)
//   reg_fmac_vc_id           VC_ID of selected slot (registered)
//   reg_vc_valid             slot valid bits
//   reg_vc_tbl_ovf           sticky table-full load drop
//
// Optional feature macro: FMAC_VC_TIME_MIN_EN enables time-at-min tracking;
// without it int_stats_timecr reads 0.

module fmac_vc_credit_bank #(
  parameter int NUM_VC = 4,
  parameter int CTR_W  = 32,
  parameter int VCID_W = 16,
  localparam int IDX_W = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [CTR_W-1:0]       reg_fmac_credit_start,
  input  logic                   reg_link_up_cnt_en,
  input  logic                   vc_tbl_clr,
  input  logic [1:0][VCID_W-1:0] vc_id,
  input  logic [1:0]             vc_id_ld,
  input  logic [1:0]             pair_vc_rdy_event,
  input  logic                   reg_sof_cnt_en,
  input  logic [VCID_W-1:0]      sof_vc_id,
  input  logic                   int_stats_latch_clr,
  input  logic [IDX_W-1:0]       stats_rd_idx,
  output logic [CTR_W-1:0]       int_stats_mincr,
  output logic [CTR_W-1:0]       int_stats_maxcr,
  output logic [CTR_W-1:0]       int_stats_endcr,
  output logic [31:0]            int_stats_timecr,
  output logic [VCID_W-1:0]      reg_fmac_vc_id,
  output logic [NUM_VC-1:0]      reg_vc_valid,
  output logic                   reg_vc_tbl_ovf
);

  localparam logic [CTR_W-1:0] CTR_RST =
    {{(CTR_W-1){1'b0}}, 1'b1} << (CTR_W - 8);

  logic [NUM_VC-1:0] valid_q, valid_d;
  logic [VCID_W-1:0] id_q [NUM_VC];
  logic [VCID_W-1:0] id_d [NUM_VC];
  logic [NUM_VC-1:0] ld_hit;
  logic              ovf_q, ovf_d;
  logic              hit_f, free_f;

  logic [CTR_W-1:0]  start_q;
  logic              reload_all;
  logic              reinit;

  logic [CTR_W-1:0]  ctr_q [NUM_VC];
  logic [CTR_W-1:0]  ctr_d [NUM_VC];

  logic [CTR_W-1:0]  run_min [NUM_VC];
  logic [CTR_W-1:0]  run_max [NUM_VC];
  logic [CTR_W-1:0]  min_nxt [NUM_VC];
  logic [CTR_W-1:0]  max_nxt [NUM_VC];
  logic [CTR_W-1:0]  lat_min [NUM_VC];
  logic [CTR_W-1:0]  lat_max [NUM_VC];
  logic [CTR_W-1:0]  lat_end [NUM_VC];

`ifdef FMAC_VC_TIME_MIN_EN
  logic [31:0]       run_tm [NUM_VC];
  logic [31:0]       tm_nxt [NUM_VC];
  logic [31:0]       lat_tm [NUM_VC];
`endif

  assign reload_all = (reg_fmac_credit_start != start_q)
                    | reg_link_up_cnt_en;
  assign reinit     = reload_all | int_stats_latch_clr;

  assign reg_vc_valid   = valid_q;
  assign reg_vc_tbl_ovf = ovf_q;

  // Saturating counter step: +rdy (0..2), -sof (0/1), clamp to [0,max].
  function automatic logic [CTR_W-1:0] step(
    input logic [CTR_W-1:0] c,
    input logic [1:0]       r,
    input logic             s
  );
    logic [CTR_W+1:0] t;
    t = {2'b00, c} + {{CTR_W{1'b0}}, r};
    if (s)
      t = (t == '0) ? '0 : t - (CTR_W+2)'(1);
    step = (t[CTR_W+1:CTR_W] != 2'b00) ? '1 : t[CTR_W-1:0];
  endfunction

  // Slot table: slot 0 request resolved first so slot 1 sees its result;
  // equal IDs therefore allocate once.
  always_comb begin
    valid_d = valid_q;
    id_d    = id_q;
    ld_hit  = '0;
    ovf_d   = ovf_q;
    hit_f   = 1'b0;
    free_f  = 1'b0;
    if (vc_tbl_clr) begin
      valid_d = '0;
      ovf_d   = 1'b0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (vc_id_ld[k]) begin
          hit_f  = 1'b0;
          free_f = 1'b0;
          for (int i = 0; i < NUM_VC; i++) begin
            if (valid_d[i] && id_d[i] == vc_id[k]) begin
              hit_f     = 1'b1;
              ld_hit[i] = 1'b1;
            end
          end
          if (!hit_f) begin
            for (int i = 0; i < NUM_VC; i++) begin
              if (!free_f && !valid_d[i]) begin
                free_f     = 1'b1;
                valid_d[i] = 1'b1;
                id_d[i]    = vc_id[k];
                ld_hit[i]  = 1'b1;
              end
            end
            if (!free_f)
              ovf_d = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_VC; i++) begin
      ctr_d[i] = ctr_q[i];
      if (reload_all || ld_hit[i])
        ctr_d[i] = reg_fmac_credit_start;
      else if (valid_q[i])
        ctr_d[i] = step(
          ctr_q[i],
          {1'b0, pair_vc_rdy_event[0] && vc_id[0] == id_q[i]}
          + {1'b0, pair_vc_rdy_event[1] && vc_id[1] == id_q[i]},
          reg_sof_cnt_en && sof_vc_id == id_q[i]);
    end
  end

  // Next running stats include this cycle's counter so a latch sees it.
  always_comb begin
    for (int i = 0; i < NUM_VC; i++) begin
      min_nxt[i] = (ctr_q[i] < run_min[i]) ? ctr_q[i] : run_min[i];
      max_nxt[i] = (ctr_q[i] > run_max[i]) ? ctr_q[i] : run_max[i];
`ifdef FMAC_VC_TIME_MIN_EN
      if (ctr_q[i] < run_min[i])
        tm_nxt[i] = 32'd1;
      else if (ctr_q[i] == run_min[i])
        tm_nxt[i] = (run_tm[i] == '1) ? run_tm[i] : run_tm[i] + 32'd1;
      else
        tm_nxt[i] = run_tm[i];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      ovf_q   <= 1'b0;
      start_q <= '0;
      for (int i = 0; i < NUM_VC; i++) begin
        id_q[i]    <= '0;
        ctr_q[i]   <= CTR_RST;
        run_min[i] <= '1;
        run_max[i] <= '0;
        lat_min[i] <= '0;
        lat_max[i] <= '0;
        lat_end[i] <= CTR_RST;
      end
    end else begin
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      start_q <= reg_fmac_credit_start;
      for (int i = 0; i < NUM_VC; i++) begin
        id_q[i]    <= id_d[i];
        ctr_q[i]   <= ctr_d[i];
        run_min[i] <= reinit ? '1 : min_nxt[i];
        run_max[i] <= reinit ? '0 : max_nxt[i];
        if (int_stats_latch_clr) begin
          lat_min[i] <= min_nxt[i];
          lat_max[i] <= max_nxt[i];
          lat_end[i] <= ctr_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_stats_mincr <= '0;
      int_stats_maxcr <= '0;
      int_stats_endcr <= CTR_RST;
      reg_fmac_vc_id  <= '0;
    end else if (int'(stats_rd_idx) < NUM_VC) begin
      int_stats_mincr <= lat_min[stats_rd_idx];
      int_stats_maxcr <= lat_max[stats_rd_idx];
      int_stats_endcr <= lat_end[stats_rd_idx];
      reg_fmac_vc_id  <= id_q[stats_rd_idx];
    end else begin
      int_stats_mincr <= '0;
      int_stats_maxcr <= '0;
      int_stats_endcr <= '0;
      reg_fmac_vc_id  <= '0;
    end
  end

`ifdef FMAC_VC_TIME_MIN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_stats_timecr <= '0;
      for (int i = 0; i < NUM_VC; i++) begin
        run_tm[i] <= '0;
        lat_tm[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_VC; i++) begin
        run_tm[i] <= reinit ? '0 : tm_nxt[i];
        if (int_stats_latch_clr)
          lat_tm[i] <= tm_nxt[i];
      end
      if (int'(stats_rd_idx) < NUM_VC)
        int_stats_timecr <= lat_tm[stats_rd_idx];
      else
        int_stats_timecr <= '0;
    end
  end
`else
  assign int_stats_timecr = '0;
`endif

endmodule

// File: tb/tb_fmac_vc_credit_bank.sv
// Directed bench for fmac_vc_credit_bank (default parameters).
// Each task drives one scenario and checks its own expected values.

module tb_fmac_vc_credit_bank;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [31:0]       reg_fmac_credit_start;
  logic              reg_link_up_cnt_en;
  logic              vc_tbl_clr;
  logic [1:0][15:0]  vc_id;
  logic [1:0]        vc_id_ld;
  logic [1:0]        pair_vc_rdy_event;
  logic              reg_sof_cnt_en;
  logic [15:0]       sof_vc_id;
  logic              int_stats_latch_clr;
  logic [1:0]        stats_rd_idx;
  logic [31:0]       int_stats_mincr;
  logic [31:0]       int_stats_maxcr;
  logic [31:0]       int_stats_endcr;
  logic [31:0]       int_stats_timecr;
  logic [15:0]       reg_fmac_vc_id;
  logic [3:0]        reg_vc_valid;
  logic              reg_vc_tbl_ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fmac_vc_credit_bank dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .reg_fmac_credit_start (reg_fmac_credit_start),
    .reg_link_up_cnt_en    (reg_link_up_cnt_en),
    .vc_tbl_clr            (vc_tbl_clr),
    .vc_id                 (vc_id),
    .vc_id_ld              (vc_id_ld),
    .pair_vc_rdy_event     (pair_vc_rdy_event),
    .reg_sof_cnt_en        (reg_sof_cnt_en),
    .sof_vc_id             (sof_vc_id),
    .int_stats_latch_clr   (int_stats_latch_clr),
    .stats_rd_idx          (stats_rd_idx),
    .int_stats_mincr       (int_stats_mincr),
    .int_stats_maxcr       (int_stats_maxcr),
    .int_stats_endcr       (int_stats_endcr),
    .int_stats_timecr      (int_stats_timecr),
    .reg_fmac_vc_id        (reg_fmac_vc_id),
    .reg_vc_valid          (reg_vc_valid),
    .reg_vc_tbl_ovf        (reg_vc_tbl_ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic latch();
    int_stats_latch_clr = 1'b1;
    tick();
    int_stats_latch_clr = 1'b0;
  endtask

  task automatic rd(input logic [1:0] idx);
    stats_rd_idx = idx;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    reg_fmac_credit_start = '0;
    reg_link_up_cnt_en = 1'b0;
    vc_tbl_clr = 1'b0;
    vc_id = '0;
    vc_id_ld = '0;
    pair_vc_rdy_event = '0;
    reg_sof_cnt_en = 1'b0;
    sof_vc_id = '0;
    int_stats_latch_clr = 1'b0;
    stats_rd_idx = '0;
    repeat (2) tick();
    total++;
    if (reg_vc_valid !== 4'b0000) begin
      bad++;
      $display("FAIL reset_valid got=%b exp=0000", reg_vc_valid);
    end
    total++;
    if (reg_vc_tbl_ovf !== 1'b0) begin
      bad++;
      $display("FAIL reset_ovf got=%b exp=0", reg_vc_tbl_ovf);
    end
    total++;
    if (int_stats_endcr !== 32'h0100_0000) begin
      bad++;
      $display("FAIL reset_endcr got=%h exp=01000000", int_stats_endcr);
    end
    total++;
    if (int_stats_mincr !== 32'h0 || int_stats_maxcr !== 32'h0 ||
        int_stats_timecr !== 32'h0 || reg_fmac_vc_id !== 16'h0) begin
      bad++;
      $display("FAIL reset_outs got=%h/%h/%h/%h exp=0",
               int_stats_mincr, int_stats_maxcr,
               int_stats_timecr, reg_fmac_vc_id);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load_sof();
    reg_fmac_credit_start = 32'd100;
    tick();
    vc_id[0] = 16'h0011;
    vc_id_ld = 2'b01;
    tick();
    vc_id_ld = 2'b00;
    total++;
    if (reg_vc_valid !== 4'b0001) begin
      bad++;
      $display("FAIL load_valid got=%b exp=0001", reg_vc_valid);
    end
    sof_vc_id = 16'h0011;
    reg_sof_cnt_en = 1'b1;
    repeat (3) tick();
    reg_sof_cnt_en = 1'b0;
    latch();
    rd(2'd0);
    total++;
    if (int_stats_endcr !== 32'd97) begin
      bad++;
      $display("FAIL sof_endcr got=%0d exp=97", int_stats_endcr);
    end
    total++;
    if (int_stats_mincr !== 32'd97 || int_stats_maxcr !== 32'd100) begin
      bad++;
      $display("FAIL sof_minmax got=%0d/%0d exp=97/100",
               int_stats_mincr, int_stats_maxcr);
    end
    total++;
    if (reg_fmac_vc_id !== 16'h0011) begin
      bad++;
      $display("FAIL slot0_id got=%h exp=0011", reg_fmac_vc_id);
    end
  endtask

  task automatic test_reload_existing();
    vc_id[0] = 16'h0011;
    vc_id_ld = 2'b01;
    tick();
    vc_id_ld = 2'b00;
    latch();
    rd(2'd0);
    total++;
    if (int_stats_endcr !== 32'd100 || reg_vc_valid !== 4'b0001) begin
      bad++;
      $display("FAIL reload_existing got=%0d/%b exp=100/0001",
               int_stats_endcr, reg_vc_valid);
    end
  endtask

  task automatic test_invalid_hold();
    vc_id = '0;
    sof_vc_id = 16'h0000;
    reg_sof_cnt_en = 1'b1;
    pair_vc_rdy_event = 2'b11;
    tick();
    reg_sof_cnt_en = 1'b0;
    pair_vc_rdy_event = 2'b00;
    latch();
    rd(2'd1);
    total++;
    if (int_stats_endcr !== 32'd100) begin
      bad++;
      $display("FAIL invalid_hold got=%0d exp=100", int_stats_endcr);
    end
  endtask

  task automatic test_saturation();
    reg_fmac_credit_start = 32'hFFFF_FFFE;
    tick();
    vc_id[0] = 16'h0011;
    vc_id[1] = 16'h0011;
    pair_vc_rdy_event = 2'b11;
    tick();
    pair_vc_rdy_event = 2'b00;
    latch();
    rd(2'd0);
    total++;
    if (int_stats_endcr !== 32'hFFFF_FFFF ||
        int_stats_maxcr !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL sat_top got=%h/%h exp=ffffffff",
               int_stats_endcr, int_stats_maxcr);
    end
    pair_vc_rdy_event = 2'b11;
    tick();
    pair_vc_rdy_event = 2'b00;
    latch();
    rd(2'd0);
    total++;
    if (int_stats_endcr !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL sat_hold got=%h exp=ffffffff", int_stats_endcr);
    end
    reg_fmac_credit_start = 32'd0;
    tick();
    sof_vc_id = 16'h0011;
    reg_sof_cnt_en = 1'b1;
    tick();
    reg_sof_cnt_en = 1'b0;
    latch();
    rd(2'd0);
    total++;
    if (int_stats_endcr !== 32'd0) begin
      bad++;
      $display("FAIL sat_zero got=%0d exp=0", int_stats_endcr);
    end
  endtask

  task automatic test_net();
    reg_fmac_credit_start = 32'd50;
    tick();
    vc_id[0] = 16'h0011;
    pair_vc_rdy_event = 2'b01;
    sof_vc_id = 16'h0011;
    reg_sof_cnt_en = 1'b1;
    tick();
    pair_vc_rdy_event = 2'b00;
    reg_sof_cnt_en = 1'b0;
    latch();
    rd(2'd0);
    total++;
    if (int_stats_endcr !== 32'd50) begin
      bad++;
      $display("FAIL net_zero got=%0d exp=50", int_stats_endcr);
    end
    vc_id[1] = 16'h0011;
    pair_vc_rdy_event = 2'b11;
    reg_sof_cnt_en = 1'b1;
    tick();
    pair_vc_rdy_event = 2'b00;
    reg_sof_cnt_en = 1'b0;
    latch();
    rd(2'd0);
    total++;
    if (int_stats_endcr !== 32'd51) begin
      bad++;
      $display("FAIL net_plus1 got=%0d exp=51", int_stats_endcr);
    end
    reg_fmac_credit_start = 32'd60;
    tick();
    latch();
    rd(2'd0);
    total++;
    if (int_stats_endcr !== 32'd60 || int_stats_mincr !== 32'd60) begin
      bad++;
      $display("FAIL start_chg0 got=%0d/%0d exp=60/60",
               int_stats_endcr, int_stats_mincr);
    end
    rd(2'd1);
    total++;
    if (int_stats_endcr !== 32'd60) begin
      bad++;
      $display("FAIL start_chg1 got=%0d exp=60", int_stats_endcr);
    end
    reg_sof_cnt_en = 1'b1;
    tick();
    reg_sof_cnt_en = 1'b0;
    reg_link_up_cnt_en = 1'b1;
    tick();
    reg_link_up_cnt_en = 1'b0;
    latch();
    rd(2'd0);
    total++;
    if (int_stats_endcr !== 32'd60) begin
      bad++;
      $display("FAIL link_up got=%0d exp=60", int_stats_endcr);
    end
  endtask

  task automatic test_time_min();
    logic [31:0] exp_tm;
`ifdef FMAC_VC_TIME_MIN_EN
    exp_tm = 32'd6;
`else
    exp_tm = 32'd0;
`endif
    reg_fmac_credit_start = 32'd10;
    tick();
    repeat (5) tick();
    latch();
    rd(2'd0);
    total++;
    if (int_stats_mincr !== 32'd10) begin
      bad++;
      $display("FAIL tmin_min got=%0d exp=10", int_stats_mincr);
    end
    total++;
    if (int_stats_timecr !== exp_tm) begin
      bad++;
      $display("FAIL tmin_time got=%0d exp=%0d", int_stats_timecr, exp_tm);
    end
    stats_rd_idx = 2'd1;
    #1;
    total++;
    if (reg_fmac_vc_id !== 16'h0011) begin
      bad++;
      $display("FAIL rd_latency_old got=%h exp=0011", reg_fmac_vc_id);
    end
    tick();
    total++;
    if (reg_fmac_vc_id !== 16'h0000) begin
      bad++;
      $display("FAIL rd_latency_new got=%h exp=0000", reg_fmac_vc_id);
    end
  endtask

  task automatic test_ovf();
    vc_tbl_clr = 1'b1;
    tick();
    vc_tbl_clr = 1'b0;
    total++;
    if (reg_vc_valid !== 4'b0000) begin
      bad++;
      $display("FAIL clr_valid got=%b exp=0000", reg_vc_valid);
    end
    vc_id[0] = 16'h0007;
    vc_id[1] = 16'h0007;
    vc_id_ld = 2'b11;
    tick();
    vc_id_ld = 2'b00;
    total++;
    if (reg_vc_valid !== 4'b0001) begin
      bad++;
      $display("FAIL equal_ids got=%b exp=0001", reg_vc_valid);
    end
    vc_tbl_clr = 1'b1;
    tick();
    vc_tbl_clr = 1'b0;
    vc_id[0] = 16'h0001;
    vc_id[1] = 16'h0002;
    vc_id_ld = 2'b11;
    tick();
    vc_id[0] = 16'h0003;
    vc_id[1] = 16'h0004;
    tick();
    vc_id_ld = 2'b00;
    total++;
    if (reg_vc_valid !== 4'b1111 || reg_vc_tbl_ovf !== 1'b0) begin
      bad++;
      $display("FAIL fill got=%b/%b exp=1111/0", reg_vc_valid, reg_vc_tbl_ovf);
    end
    rd(2'd2);
    total++;
    if (reg_fmac_vc_id !== 16'h0003) begin
      bad++;
      $display("FAIL slot2_id got=%h exp=0003", reg_fmac_vc_id);
    end
    vc_id[0] = 16'h0005;
    vc_id_ld = 2'b01;
    tick();
    vc_id_ld = 2'b00;
    total++;
    if (reg_vc_valid !== 4'b1111 || reg_vc_tbl_ovf !== 1'b1) begin
      bad++;
      $display("FAIL ovf got=%b/%b exp=1111/1", reg_vc_valid, reg_vc_tbl_ovf);
    end
    vc_id[0] = 16'h0001;
    vc_id_ld = 2'b01;
    tick();
    vc_id_ld = 2'b00;
    total++;
    if (reg_vc_tbl_ovf !== 1'b1) begin
      bad++;
      $display("FAIL ovf_sticky got=%b exp=1", reg_vc_tbl_ovf);
    end
    vc_id[0] = 16'h0009;
    vc_id_ld = 2'b01;
    vc_tbl_clr = 1'b1;
    tick();
    vc_id_ld = 2'b00;
    vc_tbl_clr = 1'b0;
    total++;
    if (reg_vc_valid !== 4'b0000 || reg_vc_tbl_ovf !== 1'b0) begin
      bad++;
      $display("FAIL clr_prio got=%b/%b exp=0000/0",
               reg_vc_valid, reg_vc_tbl_ovf);
    end
  endtask

  initial begin
    test_reset();
    test_load_sof();
    test_reload_existing();
    test_invalid_hold();
    test_saturation();
    test_net();
    test_time_min();
    test_ovf();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fmac_vc_credit_bank.md
FMAC_VC_CREDIT_BANK -- requirements
Module: fmac_vc_credit_bank

Interface
REQ-001 Parameters SHALL be: NUM_VC, default 4, number of tracked virtual channels (1..16); CTR_W, default 32, credit counter width (8..32); VCID_W, default 16, VC_ID width.
REQ-002 Ports SHALL be:
 clk  in  1  core clock, 212.5MHz.
 rst_n  in  1  asynchronous active-low reset.
 reg_fmac_credit_start  in  CTR_W  counter initial value.
 reg_link_up_cnt_en  in  1  pulse; link-up event.
 vc_tbl_clr  in  1  pulse; invalidate all VC slots.
 vc_id  in  2xVCID_W  per-slot VC_ID for VC_RDY/load.
 vc_id_ld  in  2  per-slot VC_ID load request.
 pair_vc_rdy_event  in  2  per-slot VC_RDY event.
 reg_sof_cnt_en  in  1  SOF event.
 sof_vc_id  in  VCID_W  VC_ID of SOF frame.
 int_stats_latch_clr  in  1  pulse; latch and clear interval stats.
 stats_rd_idx  in  log2(NUM_VC)  channel select for stats readout (width 1 when NUM_VC=1).
 int_stats_mincr, int_stats_maxcr, int_stats_endcr  out  CTR_W each  latched min/max/end credit of selected channel.
 int_stats_timecr  out  32  latched cycles at minimum credit of selected channel.
 reg_fmac_vc_id  out  VCID_W  VC_ID held in selected slot.
 reg_vc_valid  out  NUM_VC  slot valid bits.
 reg_vc_tbl_ovf  out  1  sticky: load dropped, table full.

Function
REQ-003 Load: vc_id_ld[k] with vc_id[k] not matching any valid slot SHALL write the lowest-index free slot, set its valid bit and set its counter to reg_fmac_credit_start next cycle.
REQ-004 Both vc_id_ld bits set in one cycle SHALL be processed slot 0 then slot 1 (two free slots consumed); equal IDs SHALL allocate once.
REQ-005 Load of an ID already valid SHALL reload that channel's counter to reg_fmac_credit_start without allocating.
REQ-006 Load with no free slot SHALL be dropped and set reg_vc_tbl_ovf; only rst_n or vc_tbl_clr clears it.
REQ-007 vc_tbl_clr SHALL clear all valid bits and reg_vc_tbl_ovf in one cycle; it takes priority over same-cycle loads.
REQ-008 Per valid channel: net = (matching pair_vc_rdy_event count, 0..2) - (matching SOF, 0/1); counter SHALL update by net the cycle after the events, saturating at 0 and 2^CTR_W-1 (e.g. max-1 with net +2 -> max).
REQ-009 A change of reg_fmac_credit_start versus its registered copy, or reg_link_up_cnt_en, SHALL reload every counter to reg_fmac_credit_start and reinitialise running stats; this takes priority over events.
REQ-010 Running stats per channel: min (init all-ones), max (init 0), time-at-min (init 0); min/max SHALL compare the registered counter each cycle; time-at-min SHALL set to 1 on new lower minimum, increment (saturating at 2^32-1) while equal to minimum.
REQ-011 int_stats_latch_clr SHALL copy every channel's min, max, counter and time-at-min into latched registers and reinitialise running stats in the same cycle.
REQ-012 Readout outputs SHALL be registered, reflecting stats_rd_idx with 1-cycle latency; out-of-range index SHALL return zeros.
REQ-013 Invalid channels SHALL ignore events and hold their counter.

Reset
REQ-014 On rst_n low: slots invalid, IDs 0, counters 2^(CTR_W-8), running min all-ones, max 0, time 0, latched end 2^(CTR_W-8), other latched stats 0, reg_vc_tbl_ovf 0, registered credit start 0, all outputs 0 except int_stats_endcr.

Configuration
REQ-015 Macro FMAC_VC_TIME_MIN_EN: defined -> time-at-min counters and int_stats_timecr as in REQ-010; undefined -> no time-at-min logic, int_stats_timecr SHALL read constant 0.

Verification
REQ-016 Load ID 0x0011 on slot 0, start 100; 3 SOF 0x0011 -> endcr 97 after latch.
REQ-017 Counter at 2^CTR_W-2, both VC_RDY matching -> saturates at 2^CTR_W-1; counter 0 with SOF -> stays 0.
REQ-018 NUM_VC=4: 5 distinct loads -> valid 4'b1111, reg_vc_tbl_ovf=1; vc_tbl_clr -> valid 0, ovf 0.
REQ-019 Start 50; SOF and one VC_RDY same cycle -> counter 50; start changed to 60 -> all counters 60, min reset.
REQ-020 Counter 10 held 5 cycles after min reached, latch -> mincr 10, timecr 6 (macro defined), 0 (undefined); readout valid 1 cycle after stats_rd_idx change.
